// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - iterative AES key expansion with round-key replay stream
//
// Purpose: expands an NK-word cipher key one word per cycle into a register
// word store, then replays round keys to the round engine over valid/ready.
// Optional feature macro: AES_KS_REVERSE_EN (honour rk_dir, allow NR..0 passes).
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start, in_key       - load key (word 0 in MSBs) and begin expansion
//   busy, keys_ready    - expansion running / complete schedule held
//   rk_req, rk_dir      - request one pass of round keys, pass direction
//   rk_valid, rk_ready  - round-key stream handshake
//   rk_round, rk_data   - round index and 128-bit round key
//   rk_last             - final key of the pass
module aes_key_sched_ctrl #(
    parameter int NK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [32*NK-1:0] in_key,
    output logic            busy,
    output logic            keys_ready,
    input  logic            rk_req,
    input  logic            rk_dir,
    output logic            rk_valid,
    input  logic            rk_ready,
    output logic [3:0]      rk_round,
    output logic [127:0]    rk_data,
    output logic            rk_last
);
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    typedef enum logic [1:0] {IDLE, EXPAND, READY, STREAM} state_t;

    state_t      state, state_nx;
    logic [31:0] w [NW];
    logic [5:0]  widx;      // index of the word written this EXPAND cycle
    logic [2:0]  wmod;      // widx % NK, tracked incrementally to avoid a divider
    logic [7:0]  rcon;
    logic [3:0]  ptr;
    logic [3:0]  ptr_first, ptr_step, ptr_end;
    logic [31:0] prev_word, old_word, t_word, new_word;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254 via an addition chain) followed
    // by the affine transform; 0 maps to 0 naturally.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

`ifdef AES_KS_REVERSE_EN
    logic dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            dir <= 1'b0;
        end else if (state == READY && !start && rk_req) begin
            dir <= rk_dir;
        end
    end

    assign ptr_first = rk_dir ? 4'(NR) : 4'd0;
    assign ptr_step  = dir ? ptr - 4'd1 : ptr + 4'd1;
    assign ptr_end   = dir ? 4'd0 : 4'(NR);
`else
    logic unused_dir;
    assign unused_dir = rk_dir;
    assign ptr_first  = 4'd0;
    assign ptr_step   = ptr + 4'd1;
    assign ptr_end    = 4'(NR);
`endif

    always_comb begin
        prev_word = w[widx - 6'd1];
        old_word  = w[widx - 6'(NK)];
        t_word    = prev_word;
        if (wmod == 3'd0) begin
            t_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
        end else if (NK == 8 && wmod == 3'd4) begin
            t_word = sub_word(prev_word);
        end
        new_word = old_word ^ t_word;
    end

    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        keys_ready = 1'b0;
        rk_valid   = 1'b0;
        rk_last    = 1'b0;
        rk_round   = 4'd0;
        rk_data    = 128'h0;
        case (state)
            IDLE: begin
                if (start) state_nx = EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                if (widx == 6'(NW - 1)) state_nx = READY;
            end
            READY: begin
                keys_ready = 1'b1;
                if (start)       state_nx = EXPAND;
                else if (rk_req) state_nx = STREAM;
            end
            STREAM: begin
                keys_ready = 1'b1;
                rk_valid   = 1'b1;
                rk_last    = (ptr == ptr_end);
                rk_round   = ptr;
                rk_data    = {w[{ptr, 2'b00}], w[{ptr, 2'b01}], w[{ptr, 2'b10}], w[{ptr, 2'b11}]};
                if (rk_ready && rk_last) state_nx = READY;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            widx  <= 6'd0;
            wmod  <= 3'd0;
            rcon  <= 8'h00;
            ptr   <= 4'd0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, READY: begin
                    if (start) begin
                        for (int k = 0; k < NK; k++) begin
                            w[k] <= in_key[32*(NK-1-k) +: 32];
                        end
                        widx <= 6'(NK);
                        wmod <= 3'd0;
                        rcon <= 8'h01;
                    end else if (state == READY && rk_req) begin
                        ptr <= ptr_first;
                    end
                end
                EXPAND: begin
                    w[widx] <= new_word;
                    widx    <= widx + 6'd1;
                    wmod    <= (wmod == 3'(NK - 1)) ? 3'd0 : wmod + 3'd1;
                    if (wmod == 3'd0) rcon <= xtime(rcon);
                end
                STREAM: begin
                    if (rk_ready && !rk_last) ptr <= ptr_step;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb/tb_aes_key_sched_ctrl.sv - self-checking bench for aes_key_sched_ctrl (NK = 4, 6, 8)
module tb_aes_key_sched_ctrl;
    logic         clk;
    logic [2:0]   rst_v, start_v, rk_req_v, rk_dir_v, rk_ready_v;
    logic [2:0]   busy_v, kr_v, val_v, last_v;
    logic [3:0]   round_v [3];
    logic [127:0] data_v  [3];
    logic [255:0] key_v   [3];

    logic [31:0]  mw  [60];
    logic [127:0] got [15];
    int           errors = 0;
    int           checks = 0;

    aes_key_sched_ctrl #(.NK(4)) dut4 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .in_key(key_v[0][127:0]),
        .busy(busy_v[0]), .keys_ready(kr_v[0]), .rk_req(rk_req_v[0]), .rk_dir(rk_dir_v[0]),
        .rk_valid(val_v[0]), .rk_ready(rk_ready_v[0]), .rk_round(round_v[0]),
        .rk_data(data_v[0]), .rk_last(last_v[0]));

    aes_key_sched_ctrl #(.NK(6)) dut6 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .in_key(key_v[1][191:0]),
        .busy(busy_v[1]), .keys_ready(kr_v[1]), .rk_req(rk_req_v[1]), .rk_dir(rk_dir_v[1]),
        .rk_valid(val_v[1]), .rk_ready(rk_ready_v[1]), .rk_round(round_v[1]),
        .rk_data(data_v[1]), .rk_last(last_v[1]));

    aes_key_sched_ctrl #(.NK(8)) dut8 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .in_key(key_v[2]),
        .busy(busy_v[2]), .keys_ready(kr_v[2]), .rk_req(rk_req_v[2]), .rk_dir(rk_dir_v[2]),
        .rk_valid(val_v[2]), .rk_ready(rk_ready_v[2]), .rk_round(round_v[2]),
        .rk_data(data_v[2]), .rk_last(last_v[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: textbook FIPS-197 expansion with integer GF arithmetic.
    function automatic int gm(input int a, input int b);
        int p = 0;
        for (int k = 0; k < 8; k++) begin
            if ((b & 1) != 0) p = p ^ a;
            a = a << 1;
            if ((a & 'h100) != 0) a = a ^ 'h11b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input int x);
        int         inv = 0;
        logic [7:0] b, c, s;
        if (x != 0) begin
            for (int y = 1; y < 256; y++) if (gm(x, y) == 1) inv = y;
        end
        b = inv[7:0];
        c = 8'h63;
        for (int k = 0; k < 8; k++)
            s[k] = b[k] ^ b[(k+4)%8] ^ b[(k+5)%8] ^ b[(k+6)%8] ^ b[(k+7)%8] ^ c[k];
        return s;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb(int'(x[31:24])), sb(int'(x[23:16])), sb(int'(x[15:8])), sb(int'(x[7:0]))};
    endfunction

    task automatic model_expand(input int nk, input logic [255:0] key);
        int          nw = 4 * (nk + 7);
        int          rc = 1;
        logic [31:0] t;
        logic [7:0]  rc8;
        for (int i = 0; i < nk; i++) mw[i] = key[32*(nk-i)-1 -: 32];
        for (int i = nk; i < nw; i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                rc8 = rc[7:0];
                t   = subw({t[23:0], t[31:24]}) ^ {rc8, 24'h0};
                rc  = gm(rc, 2);
            end else if (nk == 8 && i % nk == 4) begin
                t = subw(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        chk({tag, "_busy"},  busy_v[d],  0);
        chk({tag, "_kr"},    kr_v[d],    0);
        chk({tag, "_valid"}, val_v[d],   0);
        chk({tag, "_last"},  last_v[d],  0);
        chk({tag, "_round"}, round_v[d], 0);
        chk({tag, "_data"},  data_v[d],  0);
    endtask

    // mode 0: plain start; 1: start together with rk_req; 2: rk_req pulsed during EXPAND
    task automatic expand(input int d, input int nk, input logic [255:0] key, input int mode);
        int cnt = 0;
        model_expand(nk, key);
        @(negedge clk);
        key_v[d]   = key;
        start_v[d] = 1'b1;
        if (mode == 1) rk_req_v[d] = 1'b1;
        @(negedge clk);
        start_v[d]  = 1'b0;
        rk_req_v[d] = 1'b0;
        chk("exp_busy_first", busy_v[d], 1);
        chk("exp_valid_first", val_v[d], 0);
        while (busy_v[d] && cnt < 100) begin
            cnt++;
            if (mode == 2 && cnt == 5)  rk_req_v[d] = 1'b1;
            if (mode == 2 && cnt == 10) rk_req_v[d] = 1'b0;
            @(negedge clk);
        end
        chk("exp_busy_len", cnt, 3 * nk + 28);
        chk("exp_keys_ready", kr_v[d], 1);
        chk("exp_valid_after", val_v[d], 0);
    endtask

    // mode 0: rk_ready always 1; 1: 1,0,0 repeating; 2: random. inj pulses start mid-stream.
    task automatic pass(input int d, input int nk, input logic dir, input int mode, input bit inj);
        int          nr = nk + 6;
        int          h = 0;
        int          n = 0;
        int          r;
        logic        rdy;
        logic        eff;
        logic [255:0] key_save;
`ifdef AES_KS_REVERSE_EN
        eff = dir;
`else
        eff = 1'b0;
`endif
        key_save = key_v[d];
        @(negedge clk);
        rk_req_v[d] = 1'b1;
        rk_dir_v[d] = dir;
        @(negedge clk);
        rk_req_v[d] = 1'b0;
        while (h <= nr && n < 200) begin
            r = eff ? nr - h : h;
            chk("rk_valid", val_v[d], 1);
            chk("rk_round", round_v[d], 128'(r));
            chk("rk_data", data_v[d], {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
            chk("rk_last", last_v[d], (h == nr) ? 1 : 0);
            got[r] = data_v[d];
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (n % 3 == 0);
                default: rdy = 1'($urandom_range(1, 0));
            endcase
            start_v[d] = inj && (n == 3);
            if (inj && n == 3) key_v[d] = ~key_save;
            rk_ready_v[d] = rdy;
            @(negedge clk);
            if (rdy) h++;
            n++;
        end
        start_v[d]    = 1'b0;
        rk_ready_v[d] = 1'b0;
        key_v[d]      = key_save;
        chk("pass_handshakes", h, nr + 1);
        chk("pass_valid_after", val_v[d], 0);
        chk("pass_kr_after", kr_v[d], 1);
        chk("pass_busy_after", busy_v[d], 0);
    endtask

    initial begin
        rst_v      = 3'b111;
        start_v    = '0;
        rk_req_v   = '0;
        rk_dir_v   = '0;
        rk_ready_v = '0;
        for (int k = 0; k < 3; k++) key_v[k] = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) check_idle_outputs(k, "reset");
        rst_v = 3'b000;

        expand(0, 4, 256'h2b7e151628aed2a6abf7158809cf4f3c, 0);
        pass(0, 4, 1'b0, 0, 1'b0);
        chk("nk4_round1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("nk4_round10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        pass(0, 4, 1'b0, 1, 1'b0);
        pass(0, 4, 1'b1, 0, 1'b0);
        chk("nk4_rev_round0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        expand(1, 6, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 0);
        pass(1, 6, 1'b0, 0, 1'b0);
        chk("nk6_round12", got[12], 128'he98ba06f448c773c8ecc720401002202);

        expand(2, 8, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 0);
        pass(2, 8, 1'b0, 0, 1'b0);
        chk("nk8_round14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);

        for (int it = 0; it < 2; it++) begin
            for (int d = 0; d < 3; d++) begin
                logic [255:0] rk;
                rk = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                expand(d, 4 + 2 * d, rk, 0);
                pass(d, 4 + 2 * d, 1'($urandom_range(1, 0)), 2, 1'b0);
            end
        end

        // Reset 20 cycles into expansion.
        @(negedge clk);
        key_v[0]   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (19) @(negedge clk);
        chk("mid_busy", busy_v[0], 1);
        rst_v[0] = 1'b1;
        @(negedge clk);
        rst_v[0] = 1'b0;
        check_idle_outputs(0, "midrst");
        repeat (3) @(negedge clk);
        chk("midrst_kr_hold", kr_v[0], 0);

        expand(0, 4, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 2);
        pass(0, 4, 1'b0, 1, 1'b1);
        pass(0, 4, 1'b1, 2, 1'b0);
        expand(0, 4, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 1);
        pass(0, 4, 1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
